mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 38 +++
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation and FSM encodings,
// iteration count and small operand helpers.
package mult_div_unit_pkg;

    localparam int MDU_ITERATIONS = 32;
    localparam int MDU_CNT_W      = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

    // Magnitude of a 32-bit operand; 32'h8000_0000 maps onto itself as an unsigned value.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo, write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo, write_data,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Magnitudes are processed one bit per cycle; signs are restored in FIXUP.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    mdu_state_e             r_state, w_state_nxt;
    logic [MDU_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    mdu_op_e                r_op, w_op_nxt;
    logic [31:0]            r_addend, w_addend_nxt;
    logic [63:0]            r_work, w_work_nxt;
    logic                   r_neg_lo, w_neg_lo_nxt;
    logic                   r_neg_hi, w_neg_hi_nxt;
    logic                   r_div0, w_div0_nxt;
    logic [31:0]            r_hi, w_hi_nxt;
    logic [31:0]            r_lo, w_lo_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;

    mdu_op_e                w_op_in;
    logic                   w_sgn;
    logic [31:0]            w_mag_a;
    logic [31:0]            w_mag_b;
    logic [32:0]            w_mul_sum;
    logic [63:0]            w_mul_step;
    logic [32:0]            w_div_rem;
    logic [32:0]            w_div_diff;
    logic [63:0]            w_div_step;
    logic [63:0]            w_neg_work;
    logic [31:0]            w_fix_hi;
    logic [31:0]            w_fix_lo;

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // Operand conditioning and the single-bit multiply/divide step.
    always_comb begin
        w_op_in    = mdu_op_e'(bus.op);
        w_sgn      = op_is_signed(w_op_in);
        w_mag_a    = mag32(bus.operand_a, w_sgn);
        w_mag_b    = mag32(bus.operand_b, w_sgn);
        // Multiply: add the multiplicand when the low bit is set, then shift right.
        w_mul_sum  = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_addend} : 33'd0);
        w_mul_step = {w_mul_sum, r_work[31:1]};
        // Divide: shift the remainder left and keep the difference if it did not borrow.
        w_div_rem  = r_work[63:31];
        w_div_diff = w_div_rem - {1'b0, r_addend};
        if (w_div_diff[32]) begin
            w_div_step = {w_div_rem[31:0], r_work[30:0], 1'b0};
        end else begin
            w_div_step = {w_div_diff[31:0], r_work[30:0], 1'b1};
        end
    end

    // Sign restoration of the finished magnitude result.
    always_comb begin
        w_neg_work = 64'd0 - r_work;
        if (op_is_div(r_op)) begin
            if (r_div0) begin
                w_fix_lo = 32'hFFFF_FFFF;
            end else if (r_neg_lo) begin
                w_fix_lo = 32'd0 - r_work[31:0];
            end else begin
                w_fix_lo = r_work[31:0];
            end
            if (r_neg_hi) begin
                w_fix_hi = 32'd0 - r_work[63:32];
            end else begin
                w_fix_hi = r_work[63:32];
            end
        end else begin
            if (r_neg_lo) begin
                {w_fix_hi, w_fix_lo} = w_neg_work;
            end else begin
                {w_fix_hi, w_fix_lo} = r_work;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; CALC lingers one cycle at count zero before FIXUP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == {MDU_CNT_W{1'b0}}) begin
                    w_state_nxt = ST_FIXUP;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_FIXUP: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: datapath and HI/LO next values for each state.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_addend_nxt = r_addend;
        w_work_nxt   = r_work;
        w_neg_lo_nxt = r_neg_lo;
        w_neg_hi_nxt = r_neg_hi;
        w_div0_nxt   = r_div0;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_done_nxt   = (r_state == ST_FIXUP);
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_op_nxt     = w_op_in;
                    w_cnt_nxt    = MDU_CNT_W'(MDU_ITERATIONS);
                    w_neg_lo_nxt = w_sgn & (bus.operand_a[31] ^ bus.operand_b[31]);
                    w_neg_hi_nxt = w_sgn & bus.operand_a[31];
                    w_div0_nxt   = op_is_div(w_op_in) & (bus.operand_b == 32'd0);
                    if (op_is_div(w_op_in)) begin
                        w_addend_nxt = w_mag_b;
                        w_work_nxt   = {32'd0, w_mag_a};
                    end else begin
                        w_addend_nxt = w_mag_a;
                        w_work_nxt   = {32'd0, w_mag_b};
                    end
                end else begin
                    if (bus.mthi) begin
                        w_hi_nxt = bus.write_data;
                    end else begin
                        w_hi_nxt = r_hi;
                    end
                    if (bus.mtlo) begin
                        w_lo_nxt = bus.write_data;
                    end else begin
                        w_lo_nxt = r_lo;
                    end
                end
            end
            ST_CALC: begin
                if (r_cnt != {MDU_CNT_W{1'b0}}) begin
                    w_cnt_nxt  = r_cnt - {{(MDU_CNT_W-1){1'b0}}, 1'b1};
                    w_work_nxt = op_is_div(r_op) ? w_div_step : w_mul_step;
                end else begin
                    w_cnt_nxt  = r_cnt;
                end
            end
            ST_FIXUP: begin
                w_hi_nxt = w_fix_hi;
                w_lo_nxt = w_fix_lo;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath, result and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= {MDU_CNT_W{1'b0}};
            r_op     <= OP_MULT;
            r_addend <= 32'd0;
            r_work   <= 64'd0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_addend <= w_addend_nxt;
            r_work   <= w_work_nxt;
            r_neg_lo <= w_neg_lo_nxt;
            r_neg_hi <= w_neg_hi_nxt;
            r_div0   <= w_div0_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, randomized
// operations against an arithmetic reference model, and control-path scenarios.
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mult_div_unit_if bus();

    mult_div_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference result {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb, sq, sr;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = sa / sb;
                sr = sa % sb;
                return {sr, sq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one operation and observe the 40 edges that follow the accepting edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int done_cnt, output bit held_ok, output bit busy_ok,
                         output logic [31:0] ohi, output logic [31:0] olo);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.operand_a = $urandom; bus.operand_b = $urandom; bus.op = 2'($urandom);
        lat = -1; done_cnt = 0; held_ok = 1'b1; busy_ok = 1'b1;
        ohi = 32'hx; olo = 32'hx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k; ohi = bus.hi; olo = bus.lo;
                end
            end else if (lat < 0 && (bus.hi !== hi0 || bus.lo !== lo0)) begin
                held_ok = 1'b0;
            end
            if (bus.busy !== ((k < 34) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.write_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
            tests_failed++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, expected all zero", bus.hi, bus.lo, bus.busy, bus.done);
        end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  v_op [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
        logic [31:0] v_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] v_b  [5] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] v_hi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd0};
        logic [31:0] v_lo [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int lat, dc; bit held, bsy; logic [31:0] rh, rl;
        for (int i = 0; i < 5; i++) begin
            do_op(v_op[i], v_a[i], v_b[i], lat, dc, held, bsy, rh, rl);
            tests_run++;
            if (lat !== 34 || dc !== 1) begin
                tests_failed++;
                $display("FAIL directed_timing[%0d]: latency=%0d pulses=%0d, expected 34 and 1", i, lat, dc);
            end
            tests_run++;
            if (!held || !bsy) begin
                tests_failed++;
                $display("FAIL directed_busy_hold[%0d]: held=%b busy_ok=%b, expected 1 1", i, held, bsy);
            end
            tests_run++;
            if (rh !== v_hi[i] || rl !== v_lo[i]) begin
                tests_failed++;
                $display("FAIL directed_result[%0d]: hi=%h lo=%h, expected hi=%h lo=%h", i, rh, rl, v_hi[i], v_lo[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, dc; bit held, bsy; logic [31:0] rh, rl, a, b; logic [1:0] op; logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = 32'd0 - 32'($urandom_range(1, 9));
                default: ;
            endcase
            exp = ref_result(op, a, b);
            do_op(op, a, b, lat, dc, held, bsy, rh, rl);
            tests_run++;
            if ({rh, rl} !== exp || lat !== 34 || dc !== 1 || !held || !bsy) begin
                tests_failed++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d pulses=%0d held=%b busy_ok=%b, expected hi=%h lo=%h lat=34 pulses=1",
                         i, op, a, b, rh, rl, lat, dc, held, bsy, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat = -1; int dc = 0; logic [31:0] rh, rl; bit held = 1'b1;
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.write_data = 32'hA5A5_0000;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.op = 2'b11; bus.operand_a = 32'd100; bus.operand_b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.write_data = 32'd5;
                bus.op = 2'b01; bus.operand_a = 32'd3; bus.operand_b = 32'd3;
            end
            @(posedge clk); #1;
            bus.start = 1'b0; bus.mthi = 1'b0;
            if (bus.done === 1'b1) begin
                dc++;
                if (lat < 0) begin lat = k; rh = bus.hi; rl = bus.lo; end
            end else if (lat < 0 && (bus.hi !== 32'hA5A5_0000 || bus.lo !== 32'hA5A5_0000)) begin
                held = 1'b0;
            end
        end
        tests_run++;
        if (lat !== 34 || dc !== 1 || !held) begin
            tests_failed++;
            $display("FAIL busy_ignore_timing: latency=%0d pulses=%0d held=%b, expected 34 1 1", lat, dc, held);
        end
        tests_run++;
        if (rl !== 32'd14 || rh !== 32'd2 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignore_result: lo=%0d hi=%0d busy=%b, expected lo=14 hi=2 busy=0", rl, rh, bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int dc = 0; int nz = 0; int lat, dc2; bit held, bsy; logic [31:0] rh, rl;
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.write_data = 32'h1111_1111;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.op = 2'b01; bus.operand_a = 32'd3; bus.operand_b = 32'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort_now: hi=%h lo=%h busy=%b done=%b, expected 0 0 0 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) dc++;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) nz++;
        end
        tests_run++;
        if (dc !== 0 || nz !== 0) begin
            tests_failed++;
            $display("FAIL reset_abort_after: done cycles=%0d disturbed cycles=%0d, expected 0 0", dc, nz);
        end
        do_op(2'b00, 32'hFFFF_FFF9, 32'd3, lat, dc2, held, bsy, rh, rl);
        tests_run++;
        if (lat !== 34 || dc2 !== 1 || rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFEB) begin
            tests_failed++;
            $display("FAIL post_reset_op: lat=%0d pulses=%0d hi=%h lo=%h, expected 34 1 ffffffff ffffffeb", lat, dc2, rh, rl);
        end
    endtask

    task automatic test_mthi_mtlo();
        int lat = -1;
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.write_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        tests_run++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'hDEAD_BEEF || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h done=%b busy=%b, expected deadbeef deadbeef 0 0", bus.hi, bus.lo, bus.done, bus.busy);
        end
        @(negedge clk);
        bus.mthi = 1'b1; bus.write_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        tests_run++;
        if (bus.hi !== 32'h0BAD_F00D || bus.lo !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL mthi_only: hi=%h lo=%h, expected 0badf00d deadbeef", bus.hi, bus.lo);
        end
        @(negedge clk);
        bus.mtlo = 1'b1; bus.write_data = 32'h55; bus.start = 1'b1;
        bus.op = 2'b01; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
        @(posedge clk); #1;
        bus.mtlo = 1'b0; bus.start = 1'b0;
        tests_run++;
        if (bus.lo !== 32'hDEAD_BEEF || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_priority: lo=%h busy=%b, expected deadbeef 1", bus.lo, bus.busy);
        end
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) lat = k;
        end
        tests_run++;
        if (lat !== 34 || bus.lo !== 32'd6 || bus.hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL start_priority_result: lat=%0d hi=%h lo=%h, expected 34 0 6", lat, bus.hi, bus.lo);
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
